// File: rtl/nbody_csr.sv
`default_nettype none
// ============================================================================
// nbody_csr : Avalon-MM register front end and run sequencer for n-body core
// Rev 1.0   : initial release
// ============================================================================
module nbody_csr #(
   parameter int MAX_BODIES = 512,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  chipselect,
   input  logic                  write,
   input  logic                  read,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [63:0]           writedata,
   output logic [63:0]           readdata,
   output logic [9:0]            n_bodies,
   output logic [31:0]           gap,
   output logic                  go,
   output logic                  snap,
   output logic                  body_we,
   output logic [2:0]            body_field,
   output logic [8:0]            body_idx,
   output logic [63:0]           body_wdata,
   output logic                  mem_rd_en,
   output logic                  mem_rd_sel,
   output logic [8:0]            mem_rd_idx,
   input  logic [63:0]           mem_rd_data,
   input  logic                  core_done
);

   localparam logic [6:0] c_SEL_GO     = 7'h00;
   localparam logic [6:0] c_SEL_READ   = 7'h01;
   localparam logic [6:0] c_SEL_NB     = 7'h02;
   localparam logic [6:0] c_SEL_GAP    = 7'h08;
   localparam logic [6:0] c_SEL_DONE   = 7'h40;
   localparam logic [6:0] c_SEL_RX     = 7'h41;
   localparam logic [6:0] c_SEL_RY     = 7'h42;
   localparam logic [6:0] c_SEL_STATUS = 7'h43;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUNNING = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [9:0]    n_bodies_q;
   logic [31:0]   gap_q;
   logic [15:0]   drop_q;
   logic          go_q, snap_q, body_we_q;
   logic [2:0]    body_field_q;
   logic [8:0]    body_idx_q;
   logic [63:0]   body_wdata_q;
   logic          rd_pend_q, rd_mem_q;
   logic [63:0]   rd_val_q, readdata_q;

   logic [6:0]    w_sel;
   logic [8:0]    w_idx;
   logic          w_wr, w_rd, w_running, w_is_body, w_is_pos;
   logic          w_go_req, w_go_ok, w_snap_req, w_body_ok, w_drop;
   logic [9:0]    w_nb_clamped;
   logic [63:0]   w_rd_val;

   assign w_sel     = addr[15:9];
   assign w_idx     = addr[8:0];
   // A write wins over a simultaneous read; the read is dropped silently.
   assign w_wr      = chipselect & write;
   assign w_rd      = chipselect & read & ~write;
   assign w_running = (state_q == S_RUNNING);
   assign w_is_body = (w_sel >= 7'h03) && (w_sel <= 7'h07);
   assign w_is_pos  = (w_sel == c_SEL_RX) || (w_sel == c_SEL_RY);

   assign w_go_req   = w_wr && (w_sel == c_SEL_GO) && writedata[0];
   assign w_go_ok    = w_go_req && !w_running && (n_bodies_q >= 10'd2);
   assign w_snap_req = w_wr && (w_sel == c_SEL_READ) && writedata[0];
   assign w_body_ok  = w_wr && w_is_body && !w_running;
   assign w_drop     = (w_go_req && !w_go_ok)
                     || (w_wr && w_is_body && w_running)
                     || (w_snap_req && w_running)
                     || (w_rd && w_is_pos && w_running);

   assign w_nb_clamped = (writedata > 64'(MAX_BODIES)) ? 10'(MAX_BODIES) : writedata[9:0];

   assign mem_rd_en  = w_rd && w_is_pos && !w_running;
   assign mem_rd_sel = (w_sel == c_SEL_RY);
   assign mem_rd_idx = w_idx;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (w_go_ok)   state_d = S_RUNNING;
         S_RUNNING:      if (core_done) state_d = S_DONE;
         default:        state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Register-sourced replies are captured at request time; memory data a cycle later.
   always_comb begin
      w_rd_val = '0;
      case (w_sel)
         c_SEL_DONE:   w_rd_val = {63'b0, state_q == S_DONE};
         c_SEL_STATUS: w_rd_val = {44'b0, drop_q, 2'b0, state_q};
         default:      w_rd_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         n_bodies_q   <= '0;
         gap_q        <= '0;
         drop_q       <= '0;
         go_q         <= 1'b0;
         snap_q       <= 1'b0;
         body_we_q    <= 1'b0;
         body_field_q <= '0;
         body_idx_q   <= '0;
         body_wdata_q <= '0;
         rd_pend_q    <= 1'b0;
         rd_mem_q     <= 1'b0;
         rd_val_q     <= '0;
         readdata_q   <= '0;
      end else begin
         go_q      <= w_go_ok;
         snap_q    <= w_snap_req && !w_running;
         body_we_q <= w_body_ok;
         if (w_body_ok) begin
            body_field_q <= w_sel[2:0];
            body_idx_q   <= w_idx;
            body_wdata_q <= writedata;
         end
         if (w_wr && (w_sel == c_SEL_NB))  n_bodies_q <= w_nb_clamped;
         if (w_wr && (w_sel == c_SEL_GAP)) gap_q      <= writedata[31:0];
         if (w_drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;

         rd_pend_q <= w_rd;
         rd_mem_q  <= mem_rd_en;
         rd_val_q  <= w_rd_val;
         if (rd_pend_q) readdata_q <= rd_mem_q ? mem_rd_data : rd_val_q;
      end
   end

   assign readdata   = readdata_q;
   assign n_bodies   = n_bodies_q;
   assign gap        = gap_q;
   assign go         = go_q;
   assign snap       = snap_q;
   assign body_we    = body_we_q;
   assign body_field = body_field_q;
   assign body_idx   = body_idx_q;
   assign body_wdata = body_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_nbody_csr.sv
`default_nettype none
// ============================================================================
// tb_nbody_csr : directed + randomized bench with queue scoreboard for nbody_csr
// Rev 1.0      : initial release
// ============================================================================
module tb_nbody_csr;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        chipselect = 1'b0, write = 1'b0, read = 1'b0, core_done = 1'b0;
   logic [15:0] addr = '0;
   logic [63:0] writedata = '0;
   logic [63:0] readdata, body_wdata;
   logic [63:0] mem_rd_data = '0;
   logic [9:0]  n_bodies;
   logic [31:0] gap;
   logic        go, snap, body_we, mem_rd_en, mem_rd_sel;
   logic [2:0]  body_field;
   logic [8:0]  body_idx, mem_rd_idx;

   always #5 clk = ~clk;

   nbody_csr #(.MAX_BODIES(512), .ADDR_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .chipselect(chipselect), .write(write), .read(read),
      .addr(addr), .writedata(writedata), .readdata(readdata),
      .n_bodies(n_bodies), .gap(gap), .go(go), .snap(snap),
      .body_we(body_we), .body_field(body_field), .body_idx(body_idx),
      .body_wdata(body_wdata), .mem_rd_en(mem_rd_en), .mem_rd_sel(mem_rd_sel),
      .mem_rd_idx(mem_rd_idx), .mem_rd_data(mem_rd_data), .core_done(core_done)
   );

   // Stub position memory: X at idx 0 reads back as 1.0
   function automatic logic [63:0] stub(input logic s, input logic [8:0] i);
      return 64'h3FF0_0000_0000_0000 + (64'(s) << 32) + 64'(i);
   endfunction
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= stub(mem_rd_sel, mem_rd_idx);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0, fails = 0;
   function automatic void check(input string n, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cyc %0d: got %h, expected %h", n, cyc, act, exp);
      end
   endfunction

   typedef struct { int due; logic [2:0] f; logic [8:0] i; logic [63:0] d; } body_t;
   typedef struct { int due; logic [63:0] d; } rd_t;
   body_t bq[$];
   rd_t   rq[$];
   int    goq[$], snapq[$];

   // Reference model: 0=IDLE 1=RUNNING 2=DONE
   int          m_state = 0;
   logic [9:0]  m_nb = '0;
   logic [31:0] m_gap = '0;
   int          m_drop = 0;
   logic [63:0] last_rd = '0;
   bit          last_valid = 0;

   body_t b_mon;
   rd_t   r_mon;
   always @(negedge clk) begin
      if (goq.size() > 0 && goq[0] == cyc) begin void'(goq.pop_front()); check("go_pulse", go, 1); end
      else if (go === 1'b1) check("go_spurious", go, 0);
      if (snapq.size() > 0 && snapq[0] == cyc) begin void'(snapq.pop_front()); check("snap_pulse", snap, 1); end
      else if (snap === 1'b1) check("snap_spurious", snap, 0);
      if (bq.size() > 0 && bq[0].due == cyc) begin
         b_mon = bq.pop_front();
         check("body_we", body_we, 1);
         check("body_field", body_field, b_mon.f);
         check("body_idx", body_idx, b_mon.i);
         check("body_wdata", body_wdata, b_mon.d);
      end else if (body_we === 1'b1) check("body_we_spurious", body_we, 0);
      if (rq.size() > 0 && rq[0].due == cyc) begin
         r_mon = rq.pop_front();
         check("readdata", readdata, r_mon.d);
         last_rd = r_mon.d;
         last_valid = 1;
      end else if (last_valid && !rst) check("readdata_hold", readdata, last_rd);
   end

   function automatic logic [15:0] A(input logic [6:0] s, input logic [8:0] i);
      return {s, i};
   endfunction

   task automatic access(input logic cs, input logic w, input logic r, input logic [15:0] a,
                         input logic [63:0] wd, input logic cd);
      logic       wr, rd, pos, go_ok, drop;
      logic [6:0] s;
      logic [8:0] ix;
      logic [63:0] e;
      chipselect = cs; write = w; read = r; addr = a; writedata = wd; core_done = cd;
      wr = cs & w; rd = cs & r & ~w; s = a[15:9]; ix = a[8:0];
      pos = rd && (s == 7'h41 || s == 7'h42);
      #1;
      check("mem_rd_en", mem_rd_en, pos && m_state != 1);
      if (pos && m_state != 1) begin
         check("mem_rd_sel", mem_rd_sel, s == 7'h42);
         check("mem_rd_idx", mem_rd_idx, ix);
      end
      if (rd) begin
         case (s)
            7'h40:        e = (m_state == 2) ? 64'd1 : 64'd0;
            7'h41, 7'h42: e = (m_state == 1) ? 64'd0 : stub(s == 7'h42, ix);
            7'h43:        e = (64'(m_drop) << 4) | 64'(m_state);
            default:      e = 64'd0;
         endcase
         rq.push_back('{cyc + 2, e});
      end
      drop = pos && (m_state == 1);
      go_ok = 0;
      if (wr) begin
         if (s == 7'h00 && wd[0]) begin
            if (m_state != 1 && m_nb >= 2) go_ok = 1; else drop = 1;
         end else if (s == 7'h01 && wd[0]) begin
            if (m_state == 1) drop = 1; else snapq.push_back(cyc + 1);
         end else if (s == 7'h02) m_nb = (wd > 64'd512) ? 10'd512 : wd[9:0];
         else if (s >= 7'h03 && s <= 7'h07) begin
            if (m_state == 1) drop = 1; else bq.push_back('{cyc + 1, s[2:0], ix, wd});
         end else if (s == 7'h08) m_gap = wd[31:0];
      end
      if (m_state == 1 && cd) m_state = 2;
      else if (go_ok) begin m_state = 1; goq.push_back(cyc + 1); end
      if (drop && m_drop < 65535) m_drop++;
      @(posedge clk); #1;
      check("n_bodies", n_bodies, m_nb);
      check("gap", gap, m_gap);
   endtask

   task automatic idle();
      access(0, 0, 0, 16'h0, 64'h0, 0);
   endtask

   // Optional GO write held during the reset cycle must produce no pulse.
   task automatic do_reset(input logic go_during);
      idle();
      rst = 1; core_done = 0;
      chipselect = go_during; write = go_during; read = 0; addr = A(7'h00, 0); writedata = 64'd1;
      @(posedge clk); #1;
      rst = 0; chipselect = 0; write = 0;
      m_state = 0; m_nb = '0; m_gap = '0; m_drop = 0; last_rd = '0;
      check("rst_readdata", readdata, 0);
      check("rst_n_bodies", n_bodies, 0);
      check("rst_gap", gap, 0);
      check("rst_mem_rd_en", mem_rd_en, 0);
   endtask

   initial begin
      logic [6:0] sels [15] = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07,
                                7'h08, 7'h40, 7'h41, 7'h42, 7'h43, 7'h10, 7'h7F};
      repeat (2) @(posedge clk);
      #1;
      do_reset(0);
      access(1, 0, 1, A(7'h43, 0), 0, 0);
      access(1, 0, 1, A(7'h40, 0), 0, 0);
      access(1, 1, 0, A(7'h02, 0), 64'd21, 0);
      access(1, 1, 0, A(7'h03, 2), 64'h4034_0000_0000_0000, 0);
      access(1, 1, 0, A(7'h04, 2), 64'h0000_0000_0000_0000, 0);
      access(1, 1, 0, A(7'h06, 2), 64'hBFC9_9999_9999_999A, 0);
      access(1, 1, 0, A(7'h07, 2), 64'h3FC9_9999_9999_999A, 0);
      access(1, 1, 0, A(7'h05, 2), 64'h409F_4000_0000_0000, 0);
      access(1, 1, 0, A(7'h02, 0), 64'd1000, 0);
      access(1, 1, 0, A(7'h02, 0), 64'd1, 0);
      access(1, 1, 0, A(7'h00, 0), 64'd1, 0);
      access(1, 0, 1, A(7'h43, 0), 0, 0);
      access(1, 1, 0, A(7'h02, 0), 64'd21, 0);
      access(1, 1, 0, A(7'h08, 0), 64'd2, 0);
      access(1, 1, 0, A(7'h00, 0), 64'd1, 0);
      access(1, 0, 1, A(7'h43, 0), 0, 0);
      access(1, 1, 0, A(7'h03, 4), 64'h1234, 0);
      access(1, 0, 1, A(7'h41, 0), 0, 0);
      access(1, 1, 0, A(7'h01, 0), 64'd1, 0);
      access(0, 0, 0, 16'h0, 0, 1);
      access(1, 0, 1, A(7'h40, 0), 0, 0);
      access(1, 1, 0, A(7'h01, 0), 64'd1, 0);
      access(1, 0, 1, A(7'h41, 0), 0, 0);
      access(1, 0, 1, A(7'h42, 9'd300), 0, 0);
      access(1, 0, 1, A(7'h43, 0), 0, 0);
      access(1, 1, 0, A(7'h00, 0), 64'd1, 0);
      access(1, 1, 0, A(7'h00, 0), 64'd1, 1);
      access(1, 0, 1, A(7'h43, 0), 0, 0);
      access(1, 1, 0, A(7'h00, 0), 64'd1, 0);
      do_reset(1);
      access(1, 0, 1, A(7'h43, 0), 0, 0);
      access(1, 1, 1, A(7'h08, 0), 64'd5, 0);
      idle(); idle();

      for (int k = 0; k < 400; k++) begin
         logic [6:0]  s;
         logic [63:0] wd;
         logic        cs, w, r;
         int          mode;
         s    = sels[$urandom_range(0, 14)];
         mode = $urandom_range(0, 9);
         cs   = (mode != 0);
         w    = (mode >= 5);
         r    = (mode <= 5);
         wd   = {$urandom, $urandom};
         if (s == 7'h02 && $urandom_range(0, 3) != 0) wd = 64'($urandom_range(0, 600));
         if (s == 7'h00 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
         access(cs, w, r, A(s, 9'($urandom)), wd, $urandom_range(0, 9) == 0);
      end
      idle(); idle(); idle();
      check("queues_drained", 64'(bq.size() + rq.size() + goq.size() + snapq.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
